alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 152 +++++++++++++++
 tb/tb_alu_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer: fetches 32-bit instructions, drives an external ALU
// and retires results into an eight-entry register file.
module alu_sequencer (
  input  logic        clk,
  input  logic        resetN,
  input  logic        start,
  output logic        imemReq,
  output logic [7:0]  imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  output logic [2:0]  aluOpcode,
  output logic [31:0] aluInputA,
  output logic [31:0] aluInputB,
  input  logic [31:0] aluResult,
  input  logic        aluUpdatePC,
  output logic        busy,
  output logic        done,
  output logic [7:0]  pc,
  output logic [15:0] retired,
  input  logic [2:0]  dbgAddr,
  output logic [31:0] dbgData
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, WRITEBACK} state_t;

  localparam logic [2:0] OP_LI   = 3'd0;
  localparam logic [2:0] OP_HALT = 3'd1;
  localparam logic [2:0] OP_BEQ  = 3'd2;
  localparam logic [2:0] OP_BLT  = 3'd3;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] retired_q, retired_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] opA_q, opA_d;
  logic [31:0] opB_q, opB_d;
  logic [31:0] aluRes_q, aluRes_d;
  logic        aluFlag_q, aluFlag_d;
  logic [31:0] regs_q [8];
  logic        regWe;
  logic [31:0] regWdata;

  logic [2:0]  op, rA, rB, rD;
  logic [15:0] imm;
  logic        unusedInstrBits;

  assign op              = instr_q[31:29];
  assign rA              = instr_q[28:26];
  assign rB              = instr_q[25:23];
  assign rD              = instr_q[22:20];
  assign imm             = instr_q[15:0];
  assign unusedInstrBits = ^instr_q[19:16];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    instr_d   = instr_q;
    opA_d     = opA_q;
    opB_d     = opB_q;
    aluRes_d  = aluRes_q;
    aluFlag_d = aluFlag_q;
    regWe     = 1'b0;
    regWdata  = '0;
    imemReq   = 1'b0;
    done      = 1'b0;
    aluOpcode = '0;
    aluInputA = '0;
    aluInputB = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          pc_d      = '0;
          retired_d = '0;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        imemReq = 1'b1;
        if (imemAck) begin
          instr_d = imemData;
          state_d = DECODE;
        end
      end
      DECODE: begin
        opA_d = regs_q[rA];
        opB_d = regs_q[rB];
        if (op == OP_HALT) begin
          done      = 1'b1;
          retired_d = retired_q + 16'd1;
          state_d   = IDLE;
        end else if (op == OP_LI) begin
          state_d = WRITEBACK;
        end else begin
          state_d = EXECUTE;
        end
      end
      EXECUTE: begin
        aluOpcode = op;
        aluInputA = opA_q;
        aluInputB = opB_q;
        aluRes_d  = aluResult;
        aluFlag_d = aluUpdatePC;
        state_d   = WRITEBACK;
      end
      WRITEBACK: begin
        retired_d = retired_q + 16'd1;
        state_d   = FETCH;
        // Branch targets are relative to the branch's own address, modulo 256.
        if (op == OP_BEQ || op == OP_BLT) begin
          pc_d = aluFlag_q ? (pc_q + imm[7:0]) : (pc_q + 8'd1);
        end else begin
          pc_d     = pc_q + 8'd1;
          regWe    = 1'b1;
          regWdata = (op == OP_LI) ? {{16{imm[15]}}, imm} : aluRes_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      retired_q <= '0;
      instr_q   <= '0;
      opA_q     <= '0;
      opB_q     <= '0;
      aluRes_q  <= '0;
      aluFlag_q <= 1'b0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      instr_q   <= instr_d;
      opA_q     <= opA_d;
      opB_q     <= opB_d;
      aluRes_q  <= aluRes_d;
      aluFlag_q <= aluFlag_d;
      if (regWe) regs_q[rD] <= regWdata;
    end
  end

  assign imemAddr = pc_q;
  assign busy     = (state_q != IDLE);
  assign pc       = pc_q;
  assign retired  = retired_q;
  assign dbgData  = regs_q[dbgAddr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: drives small programs from a modelled
// instruction memory and an external ALU model, checking hand-computed results.
module tb_alu_sequencer;

  localparam logic [2:0] LI = 3'd0, HALT = 3'd1, BEQ = 3'd2, BLT = 3'd3;
  localparam logic [2:0] ADD = 3'd4, SUB = 3'd5, AND_OP = 3'd6, OR_OP = 3'd7;

  logic        clk = 1'b0;
  logic        resetN, start;
  logic        imemReq, imemAck;
  logic [7:0]  imemAddr;
  logic [31:0] imemData;
  logic [2:0]  aluOpcode;
  logic [31:0] aluInputA, aluInputB, aluResult;
  logic        aluUpdatePC;
  logic        busy, done;
  logic [7:0]  pc;
  logic [15:0] retired;
  logic [2:0]  dbgAddr;
  logic [31:0] dbgData;

  logic [31:0] imem [256];
  int          ackDelay = 0;
  bit          ackEnable = 1'b1;
  bit          forceAck = 1'b0;
  int          waitCnt = 0;
  int          assertCount = 0;
  int          failCount = 0;
  int          subCycles = 0;
  logic [31:0] subA = '0;
  logic [31:0] subB = '0;
  logic [7:0]  fetchLog [$];

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .resetN(resetN), .start(start),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
    .aluOpcode(aluOpcode), .aluInputA(aluInputA), .aluInputB(aluInputB),
    .aluResult(aluResult), .aluUpdatePC(aluUpdatePC),
    .busy(busy), .done(done), .pc(pc), .retired(retired),
    .dbgAddr(dbgAddr), .dbgData(dbgData)
  );

  // Instruction memory answers after ackDelay waiting cycles of a held request.
  assign imemData = imem[imemAddr];
  assign imemAck  = forceAck | (ackEnable & imemReq & (waitCnt == ackDelay));

  always @(posedge clk) begin
    if (imemReq && !imemAck) waitCnt <= waitCnt + 1;
    else                     waitCnt <= 0;
    if (imemReq && imemAck) fetchLog.push_back(imemAddr);
  end

  // External ALU: SUB is B-A so that SUB rD = reg[rB]-reg[rA].
  always_comb begin
    aluResult   = '0;
    aluUpdatePC = 1'b0;
    case (aluOpcode)
      BEQ:     aluUpdatePC = (aluInputA == aluInputB);
      BLT:     aluUpdatePC = ($signed(aluInputA) < $signed(aluInputB));
      ADD:     aluResult   = aluInputA + aluInputB;
      SUB:     aluResult   = aluInputB - aluInputA;
      AND_OP:  aluResult   = aluInputA & aluInputB;
      OR_OP:   aluResult   = aluInputA | aluInputB;
      default: aluResult   = '0;
    endcase
  end

  always @(negedge clk) begin
    if (aluOpcode == SUB) begin
      subCycles = subCycles + 1;
      subA      = aluInputA;
      subB      = aluInputB;
    end
  end

  function automatic logic [31:0] enc(input logic [2:0] op, input logic [2:0] ra,
                                      input logic [2:0] rb, input logic [2:0] rd,
                                      input logic [15:0] imm);
    return {op, ra, rb, rd, 4'b0000, imm};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic checkReg(input string tag, input logic [2:0] a, input logic [31:0] expected);
    @(negedge clk);
    dbgAddr = a;
    #1;
    checkOutput(tag, dbgData, expected);
  endtask

  task automatic clearImem();
    for (int i = 0; i < 256; i++) imem[i] = enc(HALT, 3'd0, 3'd0, 3'd0, 16'h0000);
  endtask

  task automatic runUntilDone(output int cycles, output bit seen);
    cycles = 0;
    seen   = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (busy === 1'b1) cycles++;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic waitAluOp(input logic [2:0] op, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (aluOpcode === op) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic waitNextFetch(output bit ok);
    int n = 0;
    while (imemReq === 1'b1 && n < 100) begin @(negedge clk); n++; end
    while (imemReq !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    ok = (n < 100) && (imemReq === 1'b1);
  endtask

  initial begin
    bit seen, ok;
    int cycles, base;

    resetN  = 1'b0;
    start   = 1'b0;
    dbgAddr = '0;
    clearImem();
    repeat (3) @(negedge clk);
    checkOutput("resetBusy", busy, 1'b0);
    checkOutput("resetDone", done, 1'b0);
    checkOutput("resetReq", imemReq, 1'b0);
    checkOutput("resetPc", pc, 8'd0);
    checkOutput("resetRetired", retired, 16'd0);
    checkOutput("resetAluOp", aluOpcode, 3'd0);
    checkOutput("resetAluA", aluInputA, 32'd0);
    resetN = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idleAfterReset", busy, 1'b0);

    $display("[TB] program 1: LI/LI/ADD/HALT");
    imem[0] = enc(LI, 3'd0, 3'd0, 3'd1, 16'd5);
    imem[1] = enc(LI, 3'd0, 3'd0, 3'd2, 16'd7);
    imem[2] = enc(ADD, 3'd1, 3'd2, 3'd3, 16'd0);
    applyStimulus();
    runUntilDone(cycles, seen);
    checkOutput("p1DoneSeen", {31'b0, seen}, 32'd1);
    checkOutput("p1BusyCycles", cycles, 32'd12);
    checkOutput("p1PcAtHalt", pc, 8'd3);
    checkOutput("p1RetiredAtHalt", retired, 16'd3);
    @(negedge clk);
    checkOutput("p1DoneOneCycle", done, 1'b0);
    checkOutput("p1BusyAfter", busy, 1'b0);
    checkOutput("p1Retired", retired, 16'd4);
    checkOutput("p1Pc", pc, 8'd3);
    checkReg("p1Reg3", 3'd3, 32'd12);
    checkReg("p1Reg1", 3'd1, 32'd5);

    $display("[TB] program 2: SUB/AND/OR");
    clearImem();
    imem[0] = enc(LI, 3'd0, 3'd0, 3'd1, 16'd3);
    imem[1] = enc(LI, 3'd0, 3'd0, 3'd2, 16'd10);
    imem[2] = enc(SUB, 3'd1, 3'd2, 3'd4, 16'd0);
    imem[3] = enc(LI, 3'd0, 3'd0, 3'd5, 16'hF0F0);
    imem[4] = enc(LI, 3'd0, 3'd0, 3'd6, 16'h0FF0);
    imem[5] = enc(AND_OP, 3'd5, 3'd6, 3'd7, 16'd0);
    imem[6] = enc(OR_OP, 3'd5, 3'd6, 3'd0, 16'd0);
    applyStimulus();
    runUntilDone(cycles, seen);
    checkOutput("p2DoneSeen", {31'b0, seen}, 32'd1);
    checkOutput("p2BusyCycles", cycles, 32'd26);
    @(negedge clk);
    checkOutput("p2Retired", retired, 16'd8);
    checkOutput("p2Pc", pc, 8'd7);
    checkOutput("p2SubCycles", subCycles, 32'd1);
    checkOutput("p2SubA", subA, 32'd3);
    checkOutput("p2SubB", subB, 32'd10);
    checkReg("p2Reg4Sub", 3'd4, 32'd7);
    checkReg("p2Reg5Sext", 3'd5, 32'hFFFF_F0F0);
    checkReg("p2Reg7And", 3'd7, 32'h0000_00F0);
    checkReg("p2Reg0Or", 3'd0, 32'hFFFF_FFF0);

    $display("[TB] program 3: branches");
    clearImem();
    imem[0]  = enc(LI, 3'd0, 3'd0, 3'd1, 16'd4);
    imem[1]  = enc(LI, 3'd0, 3'd0, 3'd2, 16'd4);
    imem[2]  = enc(BEQ, 3'd1, 3'd2, 3'd0, 16'h0008);
    imem[8]  = enc(LI, 3'd0, 3'd0, 3'd1, 16'd9);
    imem[9]  = enc(LI, 3'd0, 3'd0, 3'd7, 16'd0);
    imem[10] = enc(BEQ, 3'd1, 3'd2, 3'd0, 16'h00FE);
    imem[11] = enc(LI, 3'd0, 3'd0, 3'd1, 16'd1);
    imem[12] = enc(LI, 3'd0, 3'd0, 3'd2, 16'd2);
    imem[13] = enc(BLT, 3'd1, 3'd2, 3'd0, 16'h0005);
    base = fetchLog.size();
    applyStimulus();
    runUntilDone(cycles, seen);
    checkOutput("p3DoneSeen", {31'b0, seen}, 32'd1);
    checkOutput("p3FetchCount", fetchLog.size() - base, 32'd11);
    if (fetchLog.size() - base == 11) begin
      checkOutput("p3BeqFwd", fetchLog[base+3], 8'd10);
      checkOutput("p3BeqBack", fetchLog[base+4], 8'd8);
      checkOutput("p3BeqNotTaken", fetchLog[base+7], 8'd11);
      checkOutput("p3BltTaken", fetchLog[base+10], 8'd18);
    end
    @(negedge clk);
    checkOutput("p3Retired", retired, 16'd11);
    checkOutput("p3Pc", pc, 8'd18);
    checkReg("p3Reg7", 3'd7, 32'd0);

    $display("[TB] program 4: delayed ack, negative immediate");
    clearImem();
    ackDelay = 3;
    imem[0] = enc(LI, 3'd0, 3'd0, 3'd6, 16'h8000);
    applyStimulus();
    for (int i = 0; i < 4; i++) begin
      checkOutput("p4ReqHeld", imemReq, 1'b1);
      checkOutput("p4AddrHeld", imemAddr, 8'd0);
      @(negedge clk);
    end
    checkOutput("p4ReqDropped", imemReq, 1'b0);
    runUntilDone(cycles, seen);
    checkOutput("p4DoneSeen", {31'b0, seen}, 32'd1);
    checkOutput("p4BusyCycles", cycles, 32'd7);
    @(negedge clk);
    checkOutput("p4Retired", retired, 16'd2);
    checkReg("p4Reg6", 3'd6, 32'hFFFF_8000);
    ackDelay = 0;

    $display("[TB] program 5: pc wrap, start while busy, reset in execute");
    clearImem();
    imem[0]   = enc(BEQ, 3'd0, 3'd0, 3'd0, 16'h00FF);
    imem[255] = enc(ADD, 3'd1, 3'd2, 3'd5, 16'd0);
    applyStimulus();
    waitNextFetch(ok);
    checkOutput("p5FetchOk1", {31'b0, ok}, 32'd1);
    checkOutput("p5Fetch255", imemAddr, 8'd255);
    waitNextFetch(ok);
    checkOutput("p5FetchOk2", {31'b0, ok}, 32'd1);
    checkOutput("p5WrapAddr", imemAddr, 8'd0);
    checkOutput("p5WrapPc", pc, 8'd0);
    checkOutput("p5WrapRetired", retired, 16'd2);
    checkReg("p5Reg5", 3'd5, 32'd3);
    checkOutput("p5AluOpIdleInDecode", aluOpcode, 3'd0);
    waitAluOp(BEQ, ok);
    checkOutput("p5SawBeqExec", {31'b0, ok}, 32'd1);
    applyStimulus();
    checkOutput("p5StartIgnoredReq", imemReq, 1'b1);
    checkOutput("p5StartIgnoredAddr", imemAddr, 8'd255);
    checkOutput("p5StartIgnoredRetired", retired, 16'd3);
    waitAluOp(ADD, ok);
    checkOutput("p5SawAddExec", {31'b0, ok}, 32'd1);
    checkOutput("p5ExecA", aluInputA, 32'd1);
    checkOutput("p5ExecB", aluInputB, 32'd2);
    resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    checkOutput("p5RstBusy", busy, 1'b0);
    checkOutput("p5RstReq", imemReq, 1'b0);
    checkOutput("p5RstAluOp", aluOpcode, 3'd0);
    checkOutput("p5RstAluB", aluInputB, 32'd0);
    checkOutput("p5RstPc", pc, 8'd0);
    checkOutput("p5RstRetired", retired, 16'd0);
    for (int r = 0; r < 8; r++) checkReg("p5RstReg", r[2:0], 32'd0);
    checkOutput("p5StaysIdle", busy, 1'b0);

    $display("[TB] reset during fetch, late ack");
    clearImem();
    ackEnable = 1'b0;
    applyStimulus();
    checkOutput("rfReqUp", imemReq, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("rfReqWaiting", imemReq, 1'b1);
    resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    checkOutput("rfReqDropped", imemReq, 1'b0);
    checkOutput("rfBusy", busy, 1'b0);
    forceAck = 1'b1;
    @(negedge clk);
    forceAck = 1'b0;
    checkOutput("rfLateAckBusy", busy, 1'b0);
    checkOutput("rfLateAckReq", imemReq, 1'b0);
    checkOutput("rfLateAckRetired", retired, 16'd0);
    ackEnable = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
